bitonic_result_collector: RTL and testbench
===========================================

// Module: bitonic_result_collector
// PURPOSE
//  Receiving end of the bitonic compare/swap interface: consumes the sorter's o1/o2 result
//  pairs, re-aligns them with the enable/dir that launched them, checks ordering, groups pairs
//  into sort blocks and buffers them in a FIFO for a ready/valid downstream reader. Sits
//  directly after the sorter datapath; provides the checker/status view of the result stream.
// PARAMETERS
//  DATA_W       32  width of A/B/o1/o2
//  LAT          1   cycles from enable/dir sampled at the sorter to o1/o2 valid (>=1)
//  BLOCK_PAIRS  4   pairs per sort block (>=1)
//  FIFO_DEPTH   8   result FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1         clock, all logic on posedge
//  rst        in   1         async reset, active-low
//  enable     in   1         sorter-side launch qualifier (same cycle as A/B)
//  dir        in   1         1 = ascending (o1<=o2), 0 = descending (o1>=o2)
//  o1         in   DATA_W    sorter result, first element
//  o2         in   DATA_W    sorter result, second element
//  out_valid  out  1         FIFO head valid
//  out_ready  in   1         downstream accepts head when out_valid&out_ready
//  out_data   out  2*DATA_W  {o1,o2} of head entry
//  out_dir    out  1         dir of head entry
//  out_last   out  1         head entry closes a block
//  ord_err    out  1         1-cycle pulse: captured pair misordered for its dir
//  seq_err    out  1         1-cycle pulse: pair breaks monotonic order within block, or dir change mid-block
//  blk_done   out  1         1-cycle pulse: block of BLOCK_PAIRS pairs captured
//  overflow   out  1         sticky: a capture was dropped because FIFO full
//  pair_cnt   out  16        captured pairs, wraps at 2^16
//  err_cnt    out  8         ord_err+seq_err events, saturates at 255 (both in one cycle count 2)
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, FIFO empty, FSM IDLE, alignment pipe cleared; pairs in flight discarded.
//  Alignment: LAT-stage shift register of {enable,dir}; capture when stage LAT enable=1; o1/o2 taken that cycle.
//  Compare: unsigned. ord_err if dir=1 & o1>o2, or dir=0 & o1<o2. Misordered pair still pushed.
//  Sequence: prev = o2 of previous pair in block. Ascending needs o1>=prev; descending o1<=prev.
//    Not checked on first pair of a block. Violation -> seq_err, pair pushed, block continues.
//  FSM IDLE: capture -> idx=1, blk_dir=dir; if BLOCK_PAIRS=1 mark last, blk_done, stay IDLE; else -> COLLECT.
//  FSM COLLECT: capture with dir==blk_dir -> idx++; idx reaching BLOCK_PAIRS: out_last=1 entry,
//    blk_done pulse, -> IDLE. Capture with dir!=blk_dir: seq_err, previous entry NOT retro-marked,
//    pair becomes first of new block (idx=1, blk_dir=dir), stay COLLECT.
//  Status pulses registered: asserted cycle after capture. pair_cnt/err_cnt update same cycle.
//  FIFO: push entry {dir,last,o1,o2} on capture. Push accepted if count<FIFO_DEPTH or pop same cycle.
//    Full with no pop: entry dropped, overflow=1 until reset; FSM/counters/checks still advance.
//  Pop on out_valid&out_ready; out_data/out_dir/out_last stable while out_valid&!out_ready.
//    Empty: out_valid=0, no pop; push to empty FIFO visible at out_valid next cycle (no bypass).
//  Pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
// TESTING
//  T1 LAT=1: enable=1,dir=1 cycle n; o1=3,o2=9 cycle n+1 -> one entry {3,9}, out_dir=1, no errors, pair_cnt=1.
//  T2 dir=0, o1=5,o2=7 -> ord_err pulse, err_cnt=1, entry {5,7} still in FIFO.
//  T3 4 ascending pairs (1,2)(3,4)(2,6)(7,8) -> seq_err on 3rd pair only, out_last on 4th, blk_done once.
//  T4 out_ready=0, 9 captures, DEPTH=8 -> 8 entries held, overflow=1; drain yields first 8 pairs in order.
//  T5 full FIFO, capture and pop same cycle -> push accepted, overflow stays 0, count stays 8.
//  T6 rst low mid-block with 3 entries queued -> out_valid=0, pair_cnt=0, FSM IDLE; next capture starts fresh block.

Source files
------------

// File: rtl/bitonic_result_collector_if.sv
// Result stream from the bitonic result collector to its downstream reader.
// The collector drives head-of-FIFO data and valid; the reader returns ready.
interface bitonic_result_collector_if #(
    parameter int DATA_W = 32
);
    logic                out_valid;
    logic                out_ready;
    logic [2*DATA_W-1:0] out_data;
    logic                out_dir;
    logic                out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_dir,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_dir,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/bitonic_result_collector.sv
// Bitonic result collector: re-aligns sorter o1/o2 results with the enable/dir
// that launched them, checks pair ordering and in-block monotonic order, groups
// pairs into fixed-size sort blocks and queues them for a ready/valid reader.
module bitonic_result_collector #(
    parameter int DATA_W      = 32,
    parameter int LAT         = 1,
    parameter int BLOCK_PAIRS = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,       // asynchronous, active-low
    input  logic                       enable,    // launch qualifier at the sorter
    input  logic                       dir,       // 1 ascending, 0 descending
    input  logic [DATA_W-1:0]          o1,
    input  logic [DATA_W-1:0]          o2,
    bitonic_result_collector_if.master out_if,
    output logic                       ord_err,
    output logic                       seq_err,
    output logic                       blk_done,
    output logic                       overflow,
    output logic [15:0]                pair_cnt,
    output logic [7:0]                 err_cnt
);
    localparam int ENT_W = 2 * DATA_W + 2;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(BLOCK_PAIRS + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_PAIRS);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Saturating add of 0..2 error events into the 8-bit error counter.
    function automatic logic [7:0] err_sat_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // True when 'first' must not precede 'second' for the given direction.
    function automatic logic misordered(input logic d,
                                        input logic [DATA_W-1:0] first,
                                        input logic [DATA_W-1:0] second);
        return d ? (first > second) : (first < second);
    endfunction

    // Alignment pipe: stage k holds the launch qualifier from k cycles ago.
    logic [LAT:1] en_p;
    logic [LAT:1] dir_p;

    logic              capture;
    logic              cap_dir;
    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              blk_dir;
    logic [DATA_W-1:0] prev_o2;

    logic              ord_bad;
    logic              dir_chg;
    logic              mono_bad;
    logic              seq_bad;
    logic [IDX_W-1:0]  next_idx;
    logic              cap_last;
    logic [1:0]        err_inc;

    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_vld;
    logic              pop;
    logic              push;
    logic [ENT_W-1:0]  head;

    // Shift enable/dir down the alignment pipe so they meet their o1/o2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_p  <= '0;
            dir_p <= '0;
        end else begin
            en_p[1]  <= enable;
            dir_p[1] <= dir;
            for (int i = 2; i <= LAT; i++) begin
                en_p[i]  <= en_p[i-1];
                dir_p[i] <= dir_p[i-1];
            end
        end
    end

    assign capture = en_p[LAT];
    assign cap_dir = dir_p[LAT];

    // Pair and block checks on the pair being captured this cycle.
    always_comb begin
        ord_bad  = misordered(cap_dir, o1, o2);
        dir_chg  = (state == COLLECT) && (cap_dir != blk_dir);
        mono_bad = (state == COLLECT) && !dir_chg && misordered(cap_dir, prev_o2, o1);
        seq_bad  = dir_chg || mono_bad;
        next_idx = ((state == IDLE) || dir_chg) ? IDX_ONE : (idx + IDX_ONE);
        cap_last = (next_idx == IDX_LAST);
        err_inc  = {1'b0, ord_bad} + {1'b0, seq_bad};
    end

    // Block FSM with registered status pulses, one cycle after each capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            blk_dir  <= 1'b0;
            ord_err  <= 1'b0;
            seq_err  <= 1'b0;
            blk_done <= 1'b0;
        end else begin
            ord_err  <= capture && ord_bad;
            seq_err  <= capture && seq_bad;
            blk_done <= capture && cap_last;
            if (capture) begin
                blk_dir <= cap_dir;
                if (cap_last) begin
                    state <= IDLE;
                    idx   <= '0;
                end else begin
                    state <= COLLECT;
                    idx   <= next_idx;
                end
            end
        end
    end

    // Last o2 of the current block, the reference for the next monotonic check.
    always_ff @(posedge clk) begin
        if (capture) begin
            prev_o2 <= o2;
        end
    end

    // Pair/error counters and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair_cnt <= '0;
            err_cnt  <= '0;
            overflow <= 1'b0;
        end else if (capture) begin
            pair_cnt <= pair_cnt + 16'd1;
            err_cnt  <= err_sat_add(err_cnt, err_inc);
            if (!push) begin
                overflow <= 1'b1;
            end
        end
    end

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign fifo_vld = (count != '0);
    assign pop      = fifo_vld && out_if.out_ready;
    assign push     = capture && ((count != CNT_FULL) || pop);

    // FIFO storage; entries are {dir, last, o1, o2}.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cap_dir, cap_last, o1, o2};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head outputs read zero while the FIFO is empty so reset leaves them at 0.
    assign head             = mem[rd_ptr];
    assign out_if.out_valid = fifo_vld;
    assign out_if.out_data  = fifo_vld ? head[2*DATA_W-1:0] : '0;
    assign out_if.out_last  = fifo_vld && head[ENT_W-2];
    assign out_if.out_dir   = fifo_vld && head[ENT_W-1];
endmodule

// File: tb/tb_bitonic_result_collector.sv
// Self-checking bench for bitonic_result_collector: directed scenarios with
// hand-computed expectations plus a long randomized run against a queue model.
module tb_bitonic_result_collector;
    localparam int DATA_W = 32;
    localparam int LAT    = 1;
    localparam int BP     = 4;
    localparam int DEPTH  = 8;

    logic              clk    = 1'b0;
    logic              rst    = 1'b1;
    logic              enable = 1'b0;
    logic              dir    = 1'b0;
    logic [DATA_W-1:0] o1     = '0;
    logic [DATA_W-1:0] o2     = '0;
    logic              ord_err, seq_err, blk_done, overflow;
    logic [15:0]       pair_cnt;
    logic [7:0]        err_cnt;

    bitonic_result_collector_if #(.DATA_W(DATA_W)) oif ();

    bitonic_result_collector #(
        .DATA_W(DATA_W), .LAT(LAT), .BLOCK_PAIRS(BP), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .o1(o1), .o2(o2),
        .out_if(oif), .ord_err(ord_err), .seq_err(seq_err), .blk_done(blk_done),
        .overflow(overflow), .pair_cnt(pair_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int errors   = 0;
    int checks   = 0;
    bit checking = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic              d;
        logic              last;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } ent_t;

    ent_t              mq[$];
    bit                m_en [LAT];
    bit                m_dr [LAT];
    int                m_pos;      // pairs already in the open block, 0 = no block open
    bit                m_bdir;
    logic [DATA_W-1:0] m_prev;
    bit                e_ord, e_seq, e_done, e_ovf;
    int                e_pair, e_err;

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < LAT; i++) begin m_en[i] = 0; m_dr[i] = 0; end
        m_pos = 0; m_bdir = 0; m_prev = '0;
        e_ord = 0; e_seq = 0; e_done = 0; e_ovf = 0; e_pair = 0; e_err = 0;
    endtask

    task automatic model_step();
        bit   cap, cd, ob, sb, lst, pop;
        ent_t e;
        cap = m_en[LAT-1];
        cd  = m_dr[LAT-1];
        for (int i = LAT - 1; i > 0; i--) begin m_en[i] = m_en[i-1]; m_dr[i] = m_dr[i-1]; end
        m_en[0] = enable;
        m_dr[0] = dir;
        pop = (mq.size() != 0) && oif.out_ready;
        e_ord = 0; e_seq = 0; e_done = 0;
        if (pop) e = mq.pop_front();
        if (cap) begin
            ob = cd ? (o1 > o2) : (o1 < o2);
            sb = 0;
            if (m_pos == 0) begin
                m_pos = 1; m_bdir = cd;
            end else if (cd != m_bdir) begin
                sb = 1; m_pos = 1; m_bdir = cd;
            end else begin
                sb = cd ? (o1 < m_prev) : (o1 > m_prev);
                m_pos = m_pos + 1;
            end
            lst = (m_pos == BP);
            if (lst) m_pos = 0;
            m_prev = o2;
            e_ord  = ob; e_seq = sb; e_done = lst;
            e_pair = (e_pair + 1) % 65536;
            e_err  = e_err + int'(ob) + int'(sb);
            if (e_err > 255) e_err = 255;
            e.d = cd; e.last = lst; e.a = o1; e.b = o2;
            if (mq.size() < DEPTH) mq.push_back(e);
            else e_ovf = 1;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_clear();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    task automatic compare();
        check("out_valid", oif.out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("out_data", oif.out_data, {mq[0].a, mq[0].b});
            check("out_dir",  oif.out_dir,  mq[0].d);
            check("out_last", oif.out_last, mq[0].last);
        end
        check("ord_err",  ord_err,  e_ord);
        check("seq_err",  seq_err,  e_seq);
        check("blk_done", blk_done, e_done);
        check("overflow", overflow, e_ovf);
        check("pair_cnt", pair_cnt, e_pair);
        check("err_cnt",  err_cnt,  e_err);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (checking) compare();
        end
    end

    // ---------------- stimulus ----------------
    logic [DATA_W-1:0] dq_a[$];
    logic [DATA_W-1:0] dq_b[$];

    // One cycle: launch (en,d) now; data a/b appear on o1/o2 LAT cycles later.
    task automatic drive(input bit en, input bit d, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input bit rdy);
        @(negedge clk);
        dq_a.push_back(a);
        dq_b.push_back(b);
        if (dq_a.size() > LAT) begin
            o1 = dq_a.pop_front();
            o2 = dq_b.pop_front();
        end
        enable = en;
        dir = d;
        oif.out_ready = rdy;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(0, 0, DATA_W'($urandom), DATA_W'($urandom), rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable = 0;
        #2 rst = 0;
        @(negedge clk);
        #2 rst = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int  seqs, dones;
        bit  curdir, rdy, en;
        oif.out_ready = 0;
        #1 rst = 0;
        @(negedge clk);
        checking = 1;
        check("rst_pair_cnt", pair_cnt, 16'd0);
        check("rst_out_valid", oif.out_valid, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_err_cnt", err_cnt, 8'd0);
        #2 rst = 1;

        // T1: single ascending pair
        drive(1, 1, 3, 9, 0);
        idle(2, 0);
        check("t1_pair_cnt", pair_cnt, 16'd1);
        check("t1_out_valid", oif.out_valid, 1'b1);
        check("t1_out_data", oif.out_data, 64'h00000003_00000009);
        check("t1_out_dir", oif.out_dir, 1'b1);
        check("t1_err_cnt", err_cnt, 8'd0);

        // T2: descending pair that is misordered
        do_reset();
        drive(1, 0, 5, 7, 0);
        idle(2, 0);
        check("t2_ord_err", ord_err, 1'b1);
        check("t2_err_cnt", err_cnt, 8'd1);
        check("t2_out_data", oif.out_data, 64'h00000005_00000007);

        // T3: one block with a monotonic break on the third pair
        do_reset();
        drive(1, 1, 1, 2, 0);
        drive(1, 1, 3, 4, 0);
        drive(1, 1, 2, 6, 0);
        drive(1, 1, 7, 8, 0);
        seqs = 0; dones = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0);
            seqs += int'(seq_err);
            dones += int'(blk_done);
        end
        check("t3_seq_pulses", seqs, 1);
        check("t3_blk_done_pulses", dones, 1);
        check("t3_err_cnt", err_cnt, 8'd1);
        check("t3_pair_cnt", pair_cnt, 16'd4);
        idle(6, 1);

        // T4: nine captures into a stalled 8-deep FIFO
        do_reset();
        for (int i = 0; i < 9; i++) drive(1, 1, DATA_W'(2 * i), DATA_W'(2 * i + 1), 0);
        idle(3, 0);
        check("t4_overflow", overflow, 1'b1);
        check("t4_pair_cnt", pair_cnt, 16'd9);
        check("t4_head", oif.out_data, 64'h00000000_00000001);
        idle(12, 1);
        check("t4_drained", oif.out_valid, 1'b0);

        // T5: full FIFO with push and pop in the same cycle
        do_reset();
        for (int i = 0; i < 8; i++) drive(1, 1, DATA_W'(2 * i), DATA_W'(2 * i + 1), 0);
        drive(1, 1, 100, 101, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        check("t5_overflow", overflow, 1'b0);
        check("t5_pair_cnt", pair_cnt, 16'd9);
        check("t5_head", oif.out_data, 64'h00000002_00000003);
        idle(12, 1);

        // T6: reset in the middle of a block with entries queued
        do_reset();
        drive(1, 1, 1, 2, 0);
        drive(1, 1, 3, 4, 0);
        drive(1, 1, 5, 6, 0);
        idle(2, 0);
        check("t6_queued", oif.out_valid, 1'b1);
        @(negedge clk);
        enable = 0;
        #2 rst = 0;
        @(negedge clk);
        check("t6_rst_valid", oif.out_valid, 1'b0);
        check("t6_rst_pair_cnt", pair_cnt, 16'd0);
        #2 rst = 1;
        drive(1, 0, 9, 4, 0);
        idle(3, 0);
        check("t6_err_cnt", err_cnt, 8'd0);
        check("t6_pair_cnt", pair_cnt, 16'd1);
        check("t6_out_dir", oif.out_dir, 1'b0);
        check("t6_out_last", oif.out_last, 1'b0);

        // Randomized traffic; resets only late so err_cnt can saturate first.
        do_reset();
        curdir = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) curdir = ~curdir;
            en  = ($urandom_range(0, 9) < 7);
            rdy = ((i / 400) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (i >= 2000 && $urandom_range(0, 399) == 0) do_reset();
            drive(en, curdir, DATA_W'($urandom_range(0, 15)), DATA_W'($urandom_range(0, 15)), rdy);
        end
        idle(20, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
